// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator control/status sequencer.
//   state_e      : job sequencer states
//   REG_*        : word indices of the register map
//   CTRL_*_BIT   : bit positions inside the CTRL word
//   STAT_*_BIT   : bit positions inside the STATUS word
//   VERSION_VALUE: value returned by the VERSION word
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_SRC     = 3'd1;
    localparam logic [2:0] REG_DST     = 3'd2;
    localparam logic [2:0] REG_LEN     = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_CYCLES  = 3'd5;
    localparam logic [2:0] REG_RSVD    = 3'd6;
    localparam logic [2:0] REG_VERSION = 3'd7;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_ERROR_BIT   = 3;

    localparam int unsigned LEN_WIDTH = 16;

    localparam logic [31:0] VERSION_VALUE = 32'h0001_0000;

endpackage

// File: rtl/accel_ctrl_seq.sv
// Control/status sequencer in front of the accelerator datapath.
// Decodes word accesses from the register bridge, launches one job
// (SRC, DST, LEN) and tracks it to completion, abort or timeout.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reg_req_i/we_i/addr_i/wdata_i   register access request (zero-wait grant)
//   reg_gnt_o                       grant, equal to reg_req_i
//   reg_rvalid_o/rdata_o            response one cycle after every grant
//   core_start_o/core_abort_o       one-cycle launch / kill pulses
//   core_src_o/dst_o/len_o          job parameters, frozen from LAUNCH through RUN
//   core_done_i                     one-cycle completion pulse from the datapath
//   done_o, irq_o                   job-finished level and its gated interrupt
module accel_ctrl_seq
    import accel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INT_ADDR_WIDTH = 20,
    parameter int unsigned CTRL_WORDS     = 4,
    parameter int unsigned STAT_WORDS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_req_i,
    input  logic                      reg_we_i,
    input  logic [2:0]                reg_addr_i,
    input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
    output logic                      reg_gnt_o,
    output logic                      reg_rvalid_o,
    output logic [DATA_WIDTH-1:0]     reg_rdata_o,
    output logic                      core_start_o,
    output logic                      core_abort_o,
    output logic [INT_ADDR_WIDTH-1:0] core_src_o,
    output logic [INT_ADDR_WIDTH-1:0] core_dst_o,
    output logic [LEN_WIDTH-1:0]      core_len_o,
    input  logic                      core_done_i,
    output logic                      done_o,
    output logic                      irq_o
);

    localparam logic [DATA_WIDTH-1:0] TIMEOUT_LIMIT = DATA_WIDTH'(TIMEOUT_CYCLES);

    state_e                    state_reg, state_next;
    logic                      irq_en_reg, irq_en_next;
    logic [INT_ADDR_WIDTH-1:0] src_reg, src_next;
    logic [INT_ADDR_WIDTH-1:0] dst_reg, dst_next;
    logic [LEN_WIDTH-1:0]      len_reg, len_next;
    logic                      timeout_reg, timeout_next;
    logic                      error_reg, error_next;
    logic [DATA_WIDTH-1:0]     cycles_reg, cycles_next;
    logic [INT_ADDR_WIDTH-1:0] core_src_reg, core_src_next;
    logic [INT_ADDR_WIDTH-1:0] core_dst_reg, core_dst_next;
    logic [LEN_WIDTH-1:0]      core_len_reg, core_len_next;
    logic                      abort_pulse_reg, abort_pulse_next;
    logic                      rvalid_reg, rvalid_next;
    logic [DATA_WIDTH-1:0]     rdata_reg, rdata_next;

    logic                      wr_en, rd_en, busy;
    logic                      in_ctrl_space, in_stat_space;
    logic                      ctrl_wr, start_cmd, abort_cmd, done_clear;
    logic [DATA_WIDTH-1:0]     cycles_inc, status_word;

    // SRC is narrower than the bus; its upper write-data bits have no home.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, reg_wdata_i[DATA_WIDTH-1:INT_ADDR_WIDTH]};

    assign wr_en         = reg_req_i & reg_we_i;
    assign rd_en         = reg_req_i & ~reg_we_i;
    assign in_ctrl_space = (32'(reg_addr_i) < CTRL_WORDS);
    assign in_stat_space = (32'(reg_addr_i) >= CTRL_WORDS) &&
                           (32'(reg_addr_i) < CTRL_WORDS + STAT_WORDS);
    assign busy          = (state_reg == ST_LAUNCH) || (state_reg == ST_RUN);
    assign ctrl_wr       = wr_en && in_ctrl_space && (reg_addr_i == REG_CTRL);
    // A write carrying both start and abort is treated as abort only.
    assign abort_cmd     = ctrl_wr & reg_wdata_i[CTRL_ABORT_BIT];
    assign start_cmd     = ctrl_wr & reg_wdata_i[CTRL_START_BIT] & ~reg_wdata_i[CTRL_ABORT_BIT];
    assign done_clear    = wr_en && in_stat_space && (reg_addr_i == REG_STATUS) &&
                           reg_wdata_i[STAT_DONE_BIT];
    assign cycles_inc    = (cycles_reg == '1) ? cycles_reg : cycles_reg + 1'b1;

    always_comb begin
        status_word                   = '0;
        status_word[STAT_BUSY_BIT]    = busy;
        status_word[STAT_DONE_BIT]    = (state_reg == ST_DONE);
        status_word[STAT_TIMEOUT_BIT] = timeout_reg;
        status_word[STAT_ERROR_BIT]   = error_reg;
    end

    always_comb begin
        state_next       = state_reg;
        irq_en_next      = irq_en_reg;
        src_next         = src_reg;
        dst_next         = dst_reg;
        len_next         = len_reg;
        timeout_next     = timeout_reg;
        error_next       = error_reg;
        cycles_next      = cycles_reg;
        core_src_next    = core_src_reg;
        core_dst_next    = core_dst_reg;
        core_len_next    = core_len_reg;
        abort_pulse_next = 1'b0;
        rvalid_next      = reg_req_i;
        rdata_next       = '0;

        // Register file writes; job parameters are locked while a job is live.
        if (ctrl_wr) begin
            irq_en_next = reg_wdata_i[CTRL_IRQ_EN_BIT];
        end
        if (wr_en && in_ctrl_space && !busy) begin
            case (reg_addr_i)
                REG_SRC: src_next = reg_wdata_i[INT_ADDR_WIDTH-1:0];
                REG_DST: dst_next = reg_wdata_i[INT_ADDR_WIDTH-1:0];
                REG_LEN: len_next = reg_wdata_i[LEN_WIDTH-1:0];
                default: ;
            endcase
        end

        // Read data is captured at grant and presented with rvalid.
        if (rd_en && (in_ctrl_space || in_stat_space)) begin
            case (reg_addr_i)
                REG_CTRL:    rdata_next[CTRL_IRQ_EN_BIT] = irq_en_reg;
                REG_SRC:     rdata_next = DATA_WIDTH'(src_reg);
                REG_DST:     rdata_next = DATA_WIDTH'(dst_reg);
                REG_LEN:     rdata_next = DATA_WIDTH'(len_reg);
                REG_STATUS:  rdata_next = status_word;
                REG_CYCLES:  rdata_next = cycles_reg;
                REG_VERSION: rdata_next = DATA_WIDTH'(VERSION_VALUE);
                default:     rdata_next = '0;
            endcase
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_cmd) begin
                    timeout_next = 1'b0;
                    error_next   = 1'b0;
                    cycles_next  = '0;
                    if (len_reg != '0) begin
                        state_next    = ST_LAUNCH;
                        core_src_next = src_reg;
                        core_dst_next = dst_reg;
                        core_len_next = len_reg;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_LAUNCH: begin
                state_next = ST_RUN;
                if (start_cmd) error_next = 1'b1;
            end
            ST_RUN: begin
                cycles_next = cycles_inc;
                if (start_cmd) error_next = 1'b1;
                // Completion beats a coincident abort or timeout.
                if (core_done_i) begin
                    state_next = ST_DONE;
                end else if (abort_cmd) begin
                    state_next       = ST_IDLE;
                    abort_pulse_next = 1'b1;
                    error_next       = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cycles_inc == TIMEOUT_LIMIT)) begin
                    // Leave in the cycle that completes the allowed RUN budget.
                    state_next       = ST_IDLE;
                    abort_pulse_next = 1'b1;
                    timeout_next     = 1'b1;
                    error_next       = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_cmd) error_next = 1'b1;
                if (done_clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            irq_en_reg      <= 1'b0;
            src_reg         <= '0;
            dst_reg         <= '0;
            len_reg         <= '0;
            timeout_reg     <= 1'b0;
            error_reg       <= 1'b0;
            cycles_reg      <= '0;
            core_src_reg    <= '0;
            core_dst_reg    <= '0;
            core_len_reg    <= '0;
            abort_pulse_reg <= 1'b0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            irq_en_reg      <= irq_en_next;
            src_reg         <= src_next;
            dst_reg         <= dst_next;
            len_reg         <= len_next;
            timeout_reg     <= timeout_next;
            error_reg       <= error_next;
            cycles_reg      <= cycles_next;
            core_src_reg    <= core_src_next;
            core_dst_reg    <= core_dst_next;
            core_len_reg    <= core_len_next;
            abort_pulse_reg <= abort_pulse_next;
            rvalid_reg      <= rvalid_next;
            rdata_reg       <= rdata_next;
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = rvalid_reg;
    assign reg_rdata_o  = rdata_reg;
    assign core_start_o = (state_reg == ST_LAUNCH);
    assign core_abort_o = abort_pulse_reg;
    assign core_src_o   = core_src_reg;
    assign core_dst_o   = core_dst_reg;
    assign core_len_o   = core_len_reg;
    assign done_o       = (state_reg == ST_DONE);
    assign irq_o        = done_o & irq_en_reg;

endmodule

// File: tb/tb_accel_ctrl_seq.sv
// Self-checking bench for accel_ctrl_seq. Two instances share all inputs:
// dut uses the default timeout, dut_t a short timeout of 8 RUN cycles.
module tb_accel_ctrl_seq;

    localparam logic [2:0] A_CTRL = 3'd0, A_SRC = 3'd1, A_DST = 3'd2, A_LEN = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4, A_CYC = 3'd5, A_RSVD = 3'd6, A_VER = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        reg_req = 1'b0, reg_we = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic        core_done = 1'b0;

    logic        gnt, rvalid, core_start, core_abort, done, irq;
    logic [31:0] rdata;
    logic [19:0] core_src, core_dst;
    logic [15:0] core_len;
    logic        gnt_t, rvalid_t, core_start_t, core_abort_t, done_t, irq_t;
    logic [31:0] rdata_t;
    logic [19:0] core_src_t, core_dst_t;
    logic [15:0] core_len_t;

    int cmp_count = 0, fail_count = 0;
    int start_cnt = 0, abort_cnt = 0, abort_t_cnt = 0;

    always #5 clk = ~clk;

    accel_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .reg_req_i(reg_req), .reg_we_i(reg_we),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_gnt_o(gnt),
        .reg_rvalid_o(rvalid), .reg_rdata_o(rdata), .core_start_o(core_start),
        .core_abort_o(core_abort), .core_src_o(core_src), .core_dst_o(core_dst),
        .core_len_o(core_len), .core_done_i(core_done), .done_o(done), .irq_o(irq)
    );

    accel_ctrl_seq #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst_n(rst_n), .reg_req_i(reg_req), .reg_we_i(reg_we),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_gnt_o(gnt_t),
        .reg_rvalid_o(rvalid_t), .reg_rdata_o(rdata_t), .core_start_o(core_start_t),
        .core_abort_o(core_abort_t), .core_src_o(core_src_t), .core_dst_o(core_dst_t),
        .core_len_o(core_len_t), .core_done_i(core_done), .done_o(done_t), .irq_o(irq_t)
    );

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (core_start)   start_cnt++;
        if (core_abort)   abort_cnt++;
        if (core_abort_t) abort_t_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the n-th following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        step(1);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step(1);
        cmp_count++;
        if ({gnt, rvalid, rdata} !== {1'b1, 1'b1, 32'h0}) begin
            fail_count++;
            $display("FAIL wr_rsp addr=%0d got gnt=%b rvalid=%b rdata=%h exp 1 1 0", a, gnt, rvalid, rdata);
        end
        reg_req = 1'b0; reg_we = 1'b0;
        $display("[%0t] wr word %0d <= %h", $time, a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] dt);
        step(1);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
        step(1);
        cmp_count++;
        if ({gnt, rvalid} !== 2'b11) begin
            fail_count++;
            $display("FAIL rd_rsp addr=%0d got gnt=%b rvalid=%b exp 1 1", a, gnt, rvalid);
        end
        d = rdata; dt = rdata_t;
        reg_req = 1'b0;
        $display("[%0t] rd word %0d => %h (short-timeout copy %h)", $time, a, d, dt);
    endtask

    // Called right after the start write returns (in the LAUNCH cycle):
    // core_done_i is high during the delay-th RUN cycle.
    task automatic drive_done(input int delay);
        step(delay);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        logic [31:0] d, dt;
        rst_n = 1'b0;
        step(2);
        cmp_count++;
        if ({rvalid, core_start, core_abort, done, irq, core_src, core_dst, core_len, rdata} !== '0) begin
            fail_count++;
            $display("FAIL reset_outputs got rv=%b st=%b ab=%b dn=%b irq=%b src=%h dst=%h len=%h rd=%h exp all 0",
                     rvalid, core_start, core_abort, done, irq, core_src, core_dst, core_len, rdata);
        end
        rst_n = 1'b1;
        step(1);
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
        bus_read(A_VER, d, dt);
        cmp_count++;
        if (d !== 32'h0001_0000) begin fail_count++; $display("FAIL version got=%h exp=%h", d, 32'h0001_0000); end
        bus_read(A_RSVD, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL rsvd_read got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_normal_job();
        logic [31:0] d, dt;
        int base;
        bus_write(A_SRC, 32'h100);
        bus_write(A_DST, 32'h200);
        bus_write(A_LEN, 32'd16);
        base = start_cnt;
        bus_write(A_CTRL, 32'h5);
        cmp_count++;
        if ({core_start, core_src, core_dst, core_len} !== {1'b1, 20'h100, 20'h200, 16'd16}) begin
            fail_count++;
            $display("FAIL norm_launch got st=%b src=%h dst=%h len=%h exp 1 100 200 0010", core_start, core_src, core_dst, core_len);
        end
        drive_done(10);
        step(1);
        cmp_count++;
        if ({done, irq, 32'(start_cnt - base)} !== {1'b1, 1'b1, 32'd1}) begin
            fail_count++;
            $display("FAIL norm_done got done=%b irq=%b starts=%0d exp 1 1 1", done, irq, start_cnt - base);
        end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h2) begin fail_count++; $display("FAIL norm_status got=%h exp=%h", d, 32'h2); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd10) begin fail_count++; $display("FAIL norm_cycles got=%0d exp=%0d", d, 10); end
        bus_read(A_CTRL, d, dt);
        cmp_count++;
        if (d !== 32'h4) begin fail_count++; $display("FAIL ctrl_read got=%h exp=%h", d, 32'h4); end
        bus_write(A_STAT, 32'h2);
        step(1);
        cmp_count++;
        if ({done, irq} !== 2'b00) begin fail_count++; $display("FAIL norm_clear got done=%b irq=%b exp 0 0", done, irq); end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL norm_status_idle got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_abort();
        logic [31:0] d, dt;
        int base;
        base = abort_cnt;
        bus_write(A_CTRL, 32'h1);
        step(2);
        bus_write(A_CTRL, 32'h2);
        step(2);
        cmp_count++;
        if ({32'(abort_cnt - base), 31'd0, done} !== {32'd1, 32'd0}) begin
            fail_count++;
            $display("FAIL abort_pulse got aborts=%0d done=%b exp 1 0", abort_cnt - base, done);
        end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h8) begin fail_count++; $display("FAIL abort_status got=%h exp=%h", d, 32'h8); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd3) begin fail_count++; $display("FAIL abort_cycles got=%0d exp=%0d", d, 3); end
    endtask

    task automatic test_len_zero();
        logic [31:0] d, dt;
        int base;
        bus_write(A_LEN, 32'd0);
        base = start_cnt;
        bus_write(A_CTRL, 32'h1);
        cmp_count++;
        if (done !== 1'b1) begin fail_count++; $display("FAIL len0_done got=%b exp=1", done); end
        step(3);
        cmp_count++;
        if (start_cnt - base != 0) begin fail_count++; $display("FAIL len0_nostart got=%0d exp=0", start_cnt - base); end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h2) begin fail_count++; $display("FAIL len0_status got=%h exp=%h", d, 32'h2); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd0) begin fail_count++; $display("FAIL len0_cycles got=%0d exp=0", d); end
        bus_write(A_STAT, 32'h2);
    endtask

    task automatic test_busy_edges();
        logic [31:0] d, dt;
        int base;
        bus_write(A_SRC, 32'h111);
        bus_write(A_LEN, 32'h20);
        base = start_cnt;
        bus_write(A_CTRL, 32'h5);
        fork
            drive_done(12);
            begin
                step(2);
                bus_write(A_CTRL, 32'h1);
                bus_write(A_SRC, 32'hABC);
                cmp_count++;
                if ({core_src, core_len} !== {20'h111, 16'h20}) begin
                    fail_count++;
                    $display("FAIL busy_src_hold got src=%h len=%h exp 111 0020", core_src, core_len);
                end
            end
        join
        step(1);
        cmp_count++;
        if ({done, 32'(start_cnt - base)} !== {1'b1, 32'd1}) begin
            fail_count++;
            $display("FAIL busy_start_job got done=%b starts=%0d exp 1 1", done, start_cnt - base);
        end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'hA) begin fail_count++; $display("FAIL busy_status got=%h exp=%h", d, 32'hA); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd12) begin fail_count++; $display("FAIL busy_cycles got=%0d exp=12", d); end
        bus_read(A_SRC, d, dt);
        cmp_count++;
        if (d !== 32'h111) begin fail_count++; $display("FAIL busy_src_reg got=%h exp=%h", d, 32'h111); end
        bus_write(A_STAT, 32'h2);
    endtask

    task automatic test_done_abort_same();
        logic [31:0] d, dt;
        int base;
        base = abort_cnt;
        bus_write(A_CTRL, 32'h1);
        fork
            drive_done(6);
            begin
                step(5);
                bus_write(A_CTRL, 32'h2);
            end
        join
        step(2);
        cmp_count++;
        if ({done, 32'(abort_cnt - base)} !== {1'b1, 32'd0}) begin
            fail_count++;
            $display("FAIL done_vs_abort got done=%b aborts=%0d exp 1 0", done, abort_cnt - base);
        end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h2) begin fail_count++; $display("FAIL done_vs_abort_status got=%h exp=%h", d, 32'h2); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd6) begin fail_count++; $display("FAIL done_vs_abort_cycles got=%0d exp=6", d); end
        bus_write(A_STAT, 32'h2);
    endtask

    // Random jobs against a shadow register model: R/W regs keep their
    // implemented width, a started job reports its RUN length as CYCLES.
    task automatic test_random_jobs();
        logic [31:0] d, dt, r, exp_src, exp_dst, exp_len, exp_cyc;
        logic [15:0] len16;
        logic        irq_en;
        int delay, base;
        for (int it = 0; it < 8; it++) begin
            r = $urandom(); exp_src = r & 32'h000F_FFFF;
            bus_write(A_SRC, r);
            r = $urandom(); exp_dst = r & 32'h000F_FFFF;
            bus_write(A_DST, r);
            r = $urandom();
            len16 = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            exp_len = {16'd0, len16};
            bus_write(A_LEN, {r[31:16], len16});
            delay = $urandom_range(1, 30);
            irq_en = 1'($urandom_range(0, 1));
            exp_cyc = (len16 == 16'd0) ? 32'd0 : 32'(delay);
            base = start_cnt;
            bus_write(A_CTRL, {29'd0, irq_en, 2'b01});
            if (len16 != 16'd0) begin
                cmp_count++;
                if ({core_start, core_src, core_dst, core_len} !== {1'b1, exp_src[19:0], exp_dst[19:0], len16}) begin
                    fail_count++;
                    $display("FAIL rnd%0d_launch got st=%b src=%h dst=%h len=%h exp 1 %h %h %h",
                             it, core_start, core_src, core_dst, core_len, exp_src[19:0], exp_dst[19:0], len16);
                end
                drive_done(delay);
            end else begin
                step(2);
            end
            step(1);
            cmp_count++;
            if ({done, irq, 32'(start_cnt - base)} !== {1'b1, irq_en, (len16 != 16'd0) ? 32'd1 : 32'd0}) begin
                fail_count++;
                $display("FAIL rnd%0d_done got done=%b irq=%b starts=%0d exp 1 %b %0d",
                         it, done, irq, start_cnt - base, irq_en, (len16 != 16'd0) ? 1 : 0);
            end
            bus_read(A_STAT, d, dt);
            cmp_count++;
            if (d !== 32'h2) begin fail_count++; $display("FAIL rnd%0d_status got=%h exp=%h", it, d, 32'h2); end
            bus_read(A_CYC, d, dt);
            cmp_count++;
            if (d !== exp_cyc) begin fail_count++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", it, d, exp_cyc); end
            bus_read(A_SRC, d, dt);
            cmp_count++;
            if (d !== exp_src) begin fail_count++; $display("FAIL rnd%0d_src got=%h exp=%h", it, d, exp_src); end
            bus_read(A_LEN, d, dt);
            cmp_count++;
            if (d !== exp_len) begin fail_count++; $display("FAIL rnd%0d_len got=%h exp=%h", it, d, exp_len); end
            bus_write(A_STAT, 32'h2);
            step(1);
            cmp_count++;
            if (done !== 1'b0) begin fail_count++; $display("FAIL rnd%0d_clear got=%b exp=0", it, done); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, dt;
        int base, seen;
        do_reset();
        bus_write(A_LEN, 32'd16);
        base = abort_t_cnt;
        seen = 0;
        bus_write(A_CTRL, 32'h1);
        cmp_count++;
        if (core_start_t !== 1'b1) begin fail_count++; $display("FAIL tmo_launch got=%b exp=1", core_start_t); end
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (core_abort_t && seen == 0) seen = k;
        end
        cmp_count++;
        if (seen != 9) begin fail_count++; $display("FAIL tmo_abort_time got=%0d exp=9 (cycles after launch)", seen); end
        cmp_count++;
        if ({32'(abort_t_cnt - base), 31'd0, done_t} !== {32'd1, 32'd0}) begin
            fail_count++;
            $display("FAIL tmo_pulse got aborts=%0d done=%b exp 1 0", abort_t_cnt - base, done_t);
        end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (dt !== 32'hC) begin fail_count++; $display("FAIL tmo_status got=%h exp=%h", dt, 32'hC); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (dt !== 32'd8) begin fail_count++; $display("FAIL tmo_cycles got=%0d exp=8", dt); end
        // The default-timeout instance is still running; kill it.
        bus_write(A_CTRL, 32'h2);
        step(2);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d, dt;
        int base;
        bus_write(A_SRC, 32'h300);
        bus_write(A_LEN, 32'd16);
        bus_write(A_CTRL, 32'h5);
        step(3);
        base = abort_cnt;
        rst_n = 1'b0;
        step(1);
        cmp_count++;
        if ({rvalid, core_start, core_abort, done, irq, core_src, core_dst, core_len} !== '0) begin
            fail_count++;
            $display("FAIL midrst_outputs got rv=%b st=%b ab=%b dn=%b irq=%b src=%h dst=%h len=%h exp all 0",
                     rvalid, core_start, core_abort, done, irq, core_src, core_dst, core_len);
        end
        step(1);
        rst_n = 1'b1;
        step(3);
        cmp_count++;
        if (abort_cnt - base != 0) begin fail_count++; $display("FAIL midrst_noabort got=%0d exp=0", abort_cnt - base); end
        bus_read(A_STAT, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL midrst_status got=%h exp=%h", d, 32'h0); end
        bus_read(A_SRC, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL midrst_src got=%h exp=%h", d, 32'h0); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL midrst_cycles got=%0d exp=0", d); end
        bus_write(A_SRC, 32'h40);
        bus_write(A_LEN, 32'd5);
        bus_write(A_CTRL, 32'h1);
        cmp_count++;
        if ({core_start, core_src, core_len} !== {1'b1, 20'h40, 16'd5}) begin
            fail_count++;
            $display("FAIL midrst_newjob got st=%b src=%h len=%h exp 1 00040 0005", core_start, core_src, core_len);
        end
        drive_done(7);
        step(1);
        cmp_count++;
        if (done !== 1'b1) begin fail_count++; $display("FAIL midrst_newdone got=%b exp=1", done); end
        bus_read(A_CYC, d, dt);
        cmp_count++;
        if (d !== 32'd7) begin fail_count++; $display("FAIL midrst_newcycles got=%0d exp=7", d); end
        bus_write(A_STAT, 32'h2);
    endtask

    initial begin
        #2;
        test_reset();
        test_normal_job();
        test_abort();
        test_len_zero();
        test_busy_edges();
        test_done_abort_same();
        test_random_jobs();
        test_timeout();
        test_reset_mid_run();
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
